// File: rtl/status_transmitter_pkg.sv
// Shared glitcher definitions for the host-bound status link: record types,
// frame constants and the frame byte selector.
package status_transmitter_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 7;

    localparam logic [7:0] REC_OFFSET      = 8'h01;
    localparam logic [7:0] REC_DURATION    = 8'h02;
    localparam logic [7:0] REC_GLITCH_DONE = 8'h03;
    localparam logic [7:0] REC_RESET_DONE  = 8'h04;

    typedef struct packed {
        logic [7:0]  rtype;
        logic [31:0] data;
    } status_rec_t;

    // Byte idx of the on-wire frame; the checksum covers everything but sync.
    function automatic logic [7:0] frame_byte(input logic [7:0] sync,
                                              input status_rec_t rec,
                                              input logic [2:0] idx);
        case (idx)
            3'd0:    frame_byte = sync;
            3'd1:    frame_byte = rec.rtype;
            3'd2:    frame_byte = rec.data[31:24];
            3'd3:    frame_byte = rec.data[23:16];
            3'd4:    frame_byte = rec.data[15:8];
            3'd5:    frame_byte = rec.data[7:0];
            default: frame_byte = rec.rtype ^ rec.data[31:24] ^ rec.data[23:16]
                                ^ rec.data[15:8] ^ rec.data[7:0];
        endcase
    endfunction

endpackage

// File: rtl/status_transmitter_uart_tx_byte.sv
// 8N1 byte serialiser. ready/done rise in the last stop-bit cycle so a byte
// offered then starts its start bit on the very next cycle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);

    localparam int               CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    ser_state_t    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);
    assign done    = (state == S_STOP) && bit_end;
    assign ready   = (state == S_IDLE) || done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (valid) begin
                        shreg <= data;
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (valid) begin
                            shreg <= data;
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/status_transmitter.sv
// Host-bound status transmitter: latches one type+value record per handshake
// and sends it as a 7-byte checksummed frame over UART 8N1.
module status_transmitter
    import status_transmitter_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_valid,
    output logic             send_ready,
    input  logic [7:0]       send_type,
    input  logic [31:0]      send_data,
    output logic             dout,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {FR_IDLE, FR_SEND, FR_WAIT} frame_state_t;

    frame_state_t state;
    status_rec_t  frame_q;
    logic [2:0]   idx;
    logic         accept;
    logic         ser_valid, ser_ready, ser_done;
    logic [7:0]   ser_data;

    assign accept = send_valid && send_ready;
    assign busy   = !send_ready;

    // The sync byte goes straight to the serialiser on the accept edge, and
    // each following byte is handed over in the previous byte's last stop
    // cycle, so FR_SEND only marks a handoff and never costs a line cycle.
    always_comb begin
        ser_valid = 1'b0;
        ser_data  = SYNC_BYTE;
        if (accept) begin
            ser_valid = 1'b1;
        end else if (state == FR_WAIT && ser_ready && idx != LAST_IDX) begin
            ser_valid = 1'b1;
            ser_data  = frame_byte(SYNC_BYTE, frame_q, idx + 3'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FR_IDLE;
            frame_q     <= '0;
            idx         <= '0;
            send_ready  <= 1'b1;
            frames_sent <= '0;
        end else begin
            case (state)
                FR_IDLE: begin
                    if (accept) begin
                        frame_q    <= '{rtype: send_type, data: send_data};
                        idx        <= '0;
                        send_ready <= 1'b0;
                        state      <= FR_WAIT;
                    end
                end
                FR_SEND: state <= FR_WAIT;
                FR_WAIT: begin
                    if (ser_done) begin
                        if (idx == LAST_IDX) begin
                            state       <= FR_IDLE;
                            send_ready  <= 1'b1;
                            frames_sent <= frames_sent + CNT_W'(1);
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= FR_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .valid(ser_valid),
        .ready(ser_ready),
        .data (ser_data),
        .done (ser_done),
        .tx   (dout)
    );

endmodule

// File: tb/tb_status_transmitter.sv
// Bench for status_transmitter: line samples are decoded back into bytes and
// compared against frames built from the record contents.
`timescale 1ns/1ps
module tb_status_transmitter;

    localparam int CPB = 4;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          send_valid = 1'b0;
    logic [7:0]    send_type = '0;
    logic [31:0]   send_data = '0;
    logic          send_ready, dout, busy;
    logic [CW-1:0] frames_sent;

    int         checks = 0;
    int         errors = 0;
    logic       samp [0:599];
    logic       rdy  [0:599];
    logic [7:0] got  [0:6];
    logic       framing_ok;
    logic [CW-1:0] exp_cnt = '0;

    status_transmitter #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .send_valid(send_valid), .send_ready(send_ready),
        .send_type(send_type), .send_data(send_data), .dout(dout), .busy(busy),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_byte(input logic [7:0] t, input logic [31:0] d, input int j);
        logic [7:0] b [0:6];
        b[0] = 8'hA5; b[1] = t;
        b[2] = d[31:24]; b[3] = d[23:16]; b[4] = d[15:8]; b[5] = d[7:0];
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        return b[j];
    endfunction

    // Waits (bounded) for send_ready, then presents a record across one posedge.
    task automatic offer(input logic [7:0] t, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!send_ready && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (send_ready !== 1'b1) begin
            errors++;
            $display("FAIL offer_wait: send_ready=%b required 1 within 2000 cycles", send_ready);
        end
        send_type = t; send_data = d; send_valid = 1'b1;
        @(posedge clk);
    endtask

    // samp[k]/rdy[k] hold dout/send_ready k cycles after the accept edge.
    task automatic capture(input int n, input int drop_at, input int chg_at, input logic [31:0] chg_data);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            samp[k] = dout;
            rdy[k]  = send_ready;
            if (k == drop_at) begin
                send_valid = 1'b0; send_data = $urandom; send_type = 8'($urandom);
            end
            if (k == chg_at) send_data = chg_data;
        end
    endtask

    task automatic decode(input int base);
        logic s;
        framing_ok = 1'b1;
        for (int j = 0; j < 7; j++)
            for (int i = 0; i < 10; i++) begin
                s = samp[base + (j*10 + i)*CPB + CPB/2];
                if (i == 0 && s !== 1'b0) framing_ok = 1'b0;
                else if (i == 9 && s !== 1'b1) framing_ok = 1'b0;
                else if (i > 0 && i < 9) got[j][i-1] = s;
            end
    endtask

    task automatic test_reset;
        int bad = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 1'b1 || send_ready !== 1'b1 || busy !== 1'b0 || frames_sent !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: dout=%b ready=%b busy=%b cnt=%0d required 1 1 0 0",
                     dout, send_ready, busy, frames_sent);
        end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dout !== 1'b1 || send_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_line: %0d cycles left idle state, required 0", bad);
        end
    endtask

    task automatic test_basic;
        int low = 0;
        offer(8'h01, 32'h12345678);
        capture(281, 0, -1, 32'h0);
        decode(0);
        exp_cnt++;
        for (int k = 0; k < 280; k++) if (rdy[k] === 1'b0) low++;
        checks++;
        if (samp[0] !== 1'b0) begin
            errors++; $display("FAIL basic_latency: dout=%b one cycle after accept, required 0", samp[0]);
        end
        checks++;
        if (low != 280 || rdy[280] !== 1'b1 || samp[280] !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_window: low=%0d ready_after=%b dout_after=%b required 280 1 1",
                     low, rdy[280], samp[280]);
        end
        checks++;
        if (framing_ok !== 1'b1) begin
            errors++; $display("FAIL basic_framing: start/stop bits bad, got %b required 1", framing_ok);
        end
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (got[j] !== model_byte(8'h01, 32'h12345678, j)) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h required %h", j, got[j], model_byte(8'h01, 32'h12345678, j));
            end
        end
        checks++;
        if (frames_sent !== exp_cnt) begin
            errors++; $display("FAIL basic_count: got %0d required %0d", frames_sent, exp_cnt);
        end
    endtask

    task automatic test_checksum;
        logic [7:0]  t [0:1];
        logic [31:0] d [0:1];
        t[0] = 8'hFF; d[0] = 32'hFFFFFFFF;
        t[1] = 8'h03; d[1] = 32'h0;
        for (int f = 0; f < 2; f++) begin
            offer(t[f], d[f]);
            capture(281, 0, -1, 32'h0);
            decode(0);
            exp_cnt++;
            checks++;
            if (framing_ok !== 1'b1) begin
                errors++; $display("FAIL chk%0d_framing: got %b required 1", f, framing_ok);
            end
            for (int j = 0; j < 7; j++) begin
                checks++;
                if (got[j] !== model_byte(t[f], d[f], j)) begin
                    errors++;
                    $display("FAIL chk%0d_byte%0d: got %h required %h", f, j, got[j], model_byte(t[f], d[f], j));
                end
            end
        end
    endtask

    task automatic test_busy_ignore;
        int bad = 0;
        logic [CW-1:0] cnt_snap;
        offer(8'h02, 32'hAAAAAAAA);
        capture(562, 300, 100, 32'hBBBBBBBB);
        exp_cnt = exp_cnt + 2'd2;
        decode(0);
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (got[j] !== model_byte(8'h02, 32'hAAAAAAAA, j)) begin
                errors++;
                $display("FAIL busy_f1_byte%0d: got %h required %h", j, got[j], model_byte(8'h02, 32'hAAAAAAAA, j));
            end
        end
        // send_ready is up for a single cycle between held frames, then the next start bit
        checks++;
        if (rdy[280] !== 1'b1 || samp[280] !== 1'b1 || samp[281] !== 1'b0 || rdy[281] !== 1'b0) begin
            errors++;
            $display("FAIL busy_b2b: ready=%b dout=%b then dout=%b ready=%b required 1 1 0 0",
                     rdy[280], samp[280], samp[281], rdy[281]);
        end
        decode(281);
        checks++;
        if (framing_ok !== 1'b1) begin
            errors++; $display("FAIL busy_f2_framing: got %b required 1", framing_ok);
        end
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (got[j] !== model_byte(8'h02, 32'hBBBBBBBB, j)) begin
                errors++;
                $display("FAIL busy_f2_byte%0d: got %h required %h", j, got[j], model_byte(8'h02, 32'hBBBBBBBB, j));
            end
        end
        cnt_snap = frames_sent;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dout !== 1'b1 || frames_sent !== cnt_snap) bad++;
        end
        checks++;
        if (cnt_snap !== exp_cnt || bad != 0) begin
            errors++;
            $display("FAIL busy_two_frames: cnt=%0d stray=%0d required cnt %0d stray 0", cnt_snap, bad, exp_cnt);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        logic [7:0]  exp_bit_byte;
        d = $urandom;
        exp_bit_byte = model_byte(8'h04, d, 3);
        offer(8'h04, d);
        capture(138, 0, -1, 32'h0);
        checks++;
        if (samp[137] !== exp_bit_byte[3]) begin
            errors++; $display("FAIL arst_pre_bit: got %b required %b", samp[137], exp_bit_byte[3]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout !== 1'b1 || send_ready !== 1'b1 || busy !== 1'b0 || frames_sent !== 2'd0) begin
            errors++;
            $display("FAIL arst_immediate: dout=%b ready=%b busy=%b cnt=%0d required 1 1 0 0",
                     dout, send_ready, busy, frames_sent);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        d = $urandom;
        offer(8'h03, d);
        capture(281, 0, -1, 32'h0);
        decode(0);
        exp_cnt++;
        checks++;
        if (framing_ok !== 1'b1 || samp[0] !== 1'b0) begin
            errors++; $display("FAIL arst_fresh_framing: framing=%b start=%b required 1 0", framing_ok, samp[0]);
        end
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (got[j] !== model_byte(8'h03, d, j)) begin
                errors++; $display("FAIL arst_fresh_byte%0d: got %h required %h", j, got[j], model_byte(8'h03, d, j));
            end
        end
        checks++;
        if (frames_sent !== exp_cnt) begin
            errors++; $display("FAIL arst_fresh_count: got %0d required %0d", frames_sent, exp_cnt);
        end
    endtask

    task automatic test_counter_wrap;
        logic [CW-1:0] exp_list [0:4];
        exp_list[0] = 2'd1; exp_list[1] = 2'd2; exp_list[2] = 2'd3; exp_list[3] = 2'd0; exp_list[4] = 2'd1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_cnt = '0;
        for (int f = 0; f < 5; f++) begin
            offer(8'($urandom), $urandom);
            capture(281, 0, -1, 32'h0);
            exp_cnt++;
            checks++;
            if (frames_sent !== exp_list[f]) begin
                errors++; $display("FAIL wrap_count%0d: got %0d required %0d", f, frames_sent, exp_list[f]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0]  t;
        logic [31:0] d;
        int bad;
        for (int f = 0; f < 4; f++) begin
            t = 8'($urandom_range(1, 4));
            d = $urandom;
            offer(t, d);
            capture(281, 0, -1, 32'h0);
            decode(0);
            exp_cnt++;
            bad = 0;
            for (int j = 0; j < 7; j++) if (got[j] !== model_byte(t, d, j)) bad++;
            checks++;
            if (bad != 0 || framing_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_frame: t=%h d=%h bad_bytes=%0d framing=%b chk got %h required %h",
                         f, t, d, bad, framing_ok, got[6], model_byte(t, d, 6));
            end
            checks++;
            if (frames_sent !== exp_cnt) begin
                errors++; $display("FAIL rand%0d_count: got %0d required %0d", f, frames_sent, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum();
        test_busy_ignore();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
